// File: rtl/vc_flit_buffer_pkg.sv
// Shared types and sizing helpers for the multi-VC flit buffer.
// s_vc_flit_t is the flit view at the default 34-bit payload and 3-VC configuration.
package vc_flit_buffer_pkg;
  localparam int FLIT_W_DFLT = 34;
  localparam int VC_W_DFLT   = 2;

  typedef struct packed {
    logic [FLIT_W_DFLT-1:0] data;
    logic                   last;
    logic [VC_W_DFLT-1:0]   vc;
  } s_vc_flit_t;

  typedef enum logic [1:0] {ARB, HOLD, PKT} arb_st_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_sync_fifo.sv
// Single-clock FIFO, one per VC; extra pointer MSB separates full from empty.
module vc_sync_fifo
  import vc_flit_buffer_pkg::*;
#(
  parameter int W     = 35,
  parameter int DEPTH = 4,
  parameter int OCC_W = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  // Pointer difference is the fill level; modulo wrap keeps it exact.
  assign occ     = OCC_W'(wr_ptr - rd_ptr);
endmodule

// File: rtl/vc_flit_buffer.sv
// Multi-VC flit buffer: per-VC FIFOs drained by a round-robin arbiter,
// optionally locking the grant for the whole packet.
module vc_flit_buffer
  import vc_flit_buffer_pkg::*;
#(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int LOCK_PKT   = 1,
  parameter int VC_W       = vc_w(N_VIRT_CHN)
) (
  input  logic                                        clk_noc,
  input  logic                                        arst_noc,
  input  logic                                        flush,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [VC_W-1:0]                             in_vc,
  input  logic                                        in_last,
  input  logic [FLIT_WIDTH-1:0]                       in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [VC_W-1:0]                             out_vc,
  output logic                                        out_last,
  output logic [FLIT_WIDTH-1:0]                       out_data,
  output logic [N_VIRT_CHN*occ_w(FIFO_DEPTH)-1:0]     occupancy,
  output logic                                        err_bad_vc
);
  localparam int OCC_W = occ_w(FIFO_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [FLIT_WIDTH-1:0] data;
  } slot_t;

  logic                             rst_all, vc_ok, xfer, found;
  logic [N_VIRT_CHN-1:0]            wr_en, rd_en, full, empty;
  slot_t [N_VIRT_CHN-1:0]           head;
  logic [N_VIRT_CHN-1:0][OCC_W-1:0] occ;
  slot_t                            in_slot;
  arb_st_t                          st, st_n;
  logic [VC_W-1:0]                  gnt, gnt_n, rr_ptr, rr_n, pick, sel;

  function automatic logic [VC_W-1:0] nxt_vc(input logic [VC_W-1:0] x);
    return VC_W'((int'(x) + 1) % N_VIRT_CHN);
  endfunction

  assign rst_all   = arst_noc | flush;
  assign vc_ok     = int'(in_vc) < N_VIRT_CHN;
  assign in_ready  = vc_ok ? ~full[in_vc] : 1'b1;
  assign in_slot   = '{last: in_last, data: in_data};
  assign xfer      = out_valid && out_ready;
  assign occupancy = occ;

  for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_vc
    assign wr_en[v] = in_valid && vc_ok && (int'(in_vc) == v) && !full[v];
    assign rd_en[v] = xfer && (int'(sel) == v);
    vc_sync_fifo #(.W(FLIT_WIDTH + 1), .DEPTH(FIFO_DEPTH), .OCC_W(OCC_W)) u_fifo (
      .clk(clk_noc), .rst(rst_all), .wr_en(wr_en[v]), .wr_data(in_slot),
      .rd_en(rd_en[v]), .rd_data(head[v]), .full(full[v]), .empty(empty[v]), .occ(occ[v])
    );
  end

  // First non-empty VC at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < N_VIRT_CHN; k++) begin
      idx = (int'(rr_ptr) + k) % N_VIRT_CHN;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        pick  = VC_W'(idx);
      end
    end
  end

  always_comb begin
    sel       = (st == ARB) ? pick : gnt;
    out_valid = (st == ARB) ? found : !empty[gnt];
    out_vc    = out_valid ? sel : '0;
    out_last  = out_valid ? head[sel].last : 1'b0;
    out_data  = out_valid ? head[sel].data : '0;
  end

  always_comb begin
    st_n  = st;
    gnt_n = gnt;
    rr_n  = rr_ptr;
    case (st)
      ARB: begin
        if (xfer) begin
          rr_n = nxt_vc(sel);
          if ((LOCK_PKT != 0) && !out_last) begin
            st_n  = PKT;
            gnt_n = sel;
          end
        end else if (out_valid) begin
          st_n  = HOLD;
          gnt_n = sel;
        end
      end
      HOLD: begin
        if (xfer) begin
          rr_n = nxt_vc(gnt);
          st_n = ((LOCK_PKT != 0) && !out_last) ? PKT : ARB;
        end
      end
      PKT: begin
        if (xfer && out_last) begin
          rr_n = nxt_vc(gnt);
          st_n = ARB;
        end
      end
      default: st_n = ARB;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_all) begin
      st         <= ARB;
      gnt        <= '0;
      rr_ptr     <= '0;
      err_bad_vc <= 1'b0;
    end else begin
      st     <= st_n;
      gnt    <= gnt_n;
      rr_ptr <= rr_n;
      if (in_valid && !vc_ok) err_bad_vc <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vc_flit_buffer.sv
// Drives a LOCK_PKT=0 and a LOCK_PKT=1 buffer with the same stimulus and checks
// both every cycle against a queue-based model, plus directed literal scenarios.
module tb_vc_flit_buffer;
  import vc_flit_buffer_pkg::*;

  localparam int NV = 3, DEPTH = 4, OW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0]  in_vc = '0;
  logic [33:0] in_data = '0;

  logic              ir[2], ov[2], olast[2], err[2];
  logic [1:0]        ovc[2];
  logic [33:0]       odata[2];
  logic [NV*OW-1:0]  occ[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vc_flit_buffer #(.FLIT_WIDTH(34), .N_VIRT_CHN(NV), .FIFO_DEPTH(DEPTH), .LOCK_PKT(g)) u_dut (
      .clk_noc(clk), .arst_noc(arst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[g]), .in_vc(in_vc), .in_last(in_last), .in_data(in_data),
      .out_valid(ov[g]), .out_ready(out_ready), .out_vc(ovc[g]), .out_last(olast[g]),
      .out_data(odata[g]), .occupancy(occ[g]), .err_bad_vc(err[g])
    );
  end

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  // Model: plain queues per VC, a lock flag with its VC, and the round-robin start.
  s_vc_flit_t mq[2][NV][$];
  s_vc_flit_t tlog[2][$];
  bit         m_lock[2], m_err[2];
  int         m_gnt[2], m_rr[2];

  function automatic void m_out(input int d, output bit v, output s_vc_flit_t f);
    int c;
    v = 1'b0;
    f = '0;
    if (m_lock[d]) begin
      if (mq[d][m_gnt[d]].size() > 0) begin v = 1'b1; f = mq[d][m_gnt[d]][0]; end
    end else begin
      for (int k = 0; k < NV; k++) begin
        c = (m_rr[d] + k) % NV;
        if (!v && mq[d][c].size() > 0) begin v = 1'b1; f = mq[d][c][0]; end
      end
    end
  endfunction

  bit         u_v, u_acc;
  s_vc_flit_t u_f;
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (arst || flush) begin
        for (int c = 0; c < NV; c++) mq[d][c].delete();
        m_lock[d] = 1'b0; m_gnt[d] = 0; m_rr[d] = 0; m_err[d] = 1'b0;
      end else begin
        m_out(d, u_v, u_f);
        u_acc = in_valid && (int'(in_vc) < NV) && (mq[d][in_vc].size() < DEPTH);
        if (in_valid && int'(in_vc) >= NV) m_err[d] = 1'b1;
        if (u_v && out_ready) begin
          void'(mq[d][u_f.vc].pop_front());
          m_rr[d]   = (int'(u_f.vc) + 1) % NV;
          m_lock[d] = (d == 1) && !u_f.last;
          m_gnt[d]  = int'(u_f.vc);
        end else if (u_v) begin
          m_lock[d] = 1'b1;
          m_gnt[d]  = int'(u_f.vc);
        end
        if (u_acc) mq[d][in_vc].push_back('{data: in_data, last: in_last, vc: in_vc});
      end
    end
  end

  bit               c_v;
  s_vc_flit_t       c_f;
  logic [NV*OW-1:0] c_eo;
  logic             c_ei;
  logic [48:0]      c_exp, c_act;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        m_out(d, c_v, c_f);
        for (int c = 0; c < NV; c++) c_eo[c*OW +: OW] = OW'(mq[d][c].size());
        c_ei  = (int'(in_vc) >= NV) ? 1'b1 : (mq[d][in_vc].size() < DEPTH);
        c_exp = {c_v, c_v ? c_f.vc : 2'b0, c_v ? c_f.last : 1'b0, c_v ? c_f.data : 34'h0,
                 c_eo, m_err[d], c_ei};
        c_act = {ov[d], ovc[d], olast[d], odata[d], occ[d], err[d], ir[d]};
        tests++;
        if (c_act !== c_exp) begin
          fails++;
          $display("FAIL model_dut%0d t=%0t act=%h exp=%h", d, $time, c_act, c_exp);
        end
        if (ov[d] && out_ready) tlog[d].push_back('{data: odata[d], last: olast[d], vc: ovc[d]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lchk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic wr(input logic [1:0] vc, input logic [33:0] dat, input logic lst);
    in_valid = 1'b1; in_vc = vc; in_data = dat; in_last = lst;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick(); tick();
    arst = 1'b0;
  endtask

  task automatic clr_logs();
    tlog[0].delete();
    tlog[1].delete();
  endtask

  task automatic chk_log(input int d, input int idx, input logic [1:0] vc, input logic [33:0] dat);
    tests++;
    if (tlog[d].size() <= idx) begin
      fails++;
      $display("FAIL log_dut%0d[%0d] missing, size=%0d", d, idx, tlog[d].size());
    end else if (tlog[d][idx].vc !== vc || tlog[d][idx].data !== dat) begin
      fails++;
      $display("FAIL log_dut%0d[%0d] act=vc%0d/%0h exp=vc%0d/%0h", d, idx,
               tlog[d][idx].vc, tlog[d][idx].data, vc, dat);
    end
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lchk("rst_out_valid", ov[d], 0);
      lchk("rst_in_ready", ir[d], 1);
      lchk("rst_occ", occ[d], 0);
      lchk("rst_err", err[d], 0);
    end

    // Fill VC1 with out_ready low.
    out_ready = 1'b0;
    wr(1, 34'hA, 0); wr(1, 34'hB, 0); wr(1, 34'hC, 0); wr(1, 34'hD, 1);
    in_vc = 1; #1;
    for (int d = 0; d < 2; d++) begin
      lchk("fill_occ_vc1", occ[d][OW +: OW], 4);
      lchk("fill_ready_vc1", ir[d], 0);
    end
    in_vc = 0; #1;
    for (int d = 0; d < 2; d++) lchk("fill_ready_vc0", ir[d], 1);
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      lchk("hold_valid", ov[d], 1);
      lchk("hold_data", odata[d], 34'hA);
      lchk("hold_vc", ovc[d], 1);
    end

    // Full VC0: a write refused while the head is drained.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(0, 34'h10 + 34'(i), 1);
    in_valid = 1'b1; in_vc = 0; in_data = 34'h55; in_last = 1'b1; out_ready = 1'b1; #1;
    for (int d = 0; d < 2; d++) lchk("full_ready", ir[d], 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      lchk("full_occ_after", occ[d][0 +: OW], 3);
      lchk("full_ready_after", ir[d], 1);
    end

    // Out-of-range VC.
    in_valid = 1'b1; in_vc = 3; in_data = 34'h77; #1;
    for (int d = 0; d < 2; d++) lchk("badvc_ready", ir[d], 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      lchk("badvc_err", err[d], 1);
      lchk("badvc_occ", occ[d], 9'(3));
    end
    flush = 1'b1; tick(); flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lchk("flush_err", err[d], 0);
      lchk("flush_occ", occ[d], 0);
    end

    // Round robin over single-flit packets.
    do_reset();
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < NV; v++) wr(2'(v), 34'h100 + 34'(r*16 + v), 1);
    clr_logs();
    out_ready = 1'b1;
    repeat (10) tick();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 6; i++) chk_log(d, i, 2'(i % 3), 34'h100 + 34'((i / 3)*16 + (i % 3)));

    // Packet lock: VC2 packet with a late middle flit, VC0 single flit.
    do_reset();
    clr_logs();
    out_ready = 1'b1;
    wr(2, 34'h200, 0); wr(0, 34'h300, 1);
    tick(); tick(); tick();
    wr(2, 34'h201, 0); wr(2, 34'h202, 1);
    repeat (4) tick();
    chk_log(1, 0, 2, 34'h200); chk_log(1, 1, 2, 34'h201);
    chk_log(1, 2, 2, 34'h202); chk_log(1, 3, 0, 34'h300);
    chk_log(0, 0, 2, 34'h200); chk_log(0, 1, 0, 34'h300);
    chk_log(0, 2, 2, 34'h201); chk_log(0, 3, 2, 34'h202);

    // Flush while locked on VC1.
    do_reset();
    out_ready = 1'b0;
    wr(3, 34'h0, 0);
    out_ready = 1'b1;
    wr(1, 34'h400, 0); wr(1, 34'h401, 0);
    out_ready = 1'b0;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lchk("fl_occ", occ[d], 0);
      lchk("fl_valid", ov[d], 0);
      lchk("fl_err", err[d], 0);
    end
    clr_logs();
    out_ready = 1'b1;
    wr(0, 34'h500, 1);
    tick(); tick(); tick();
    chk_log(1, 0, 0, 34'h500);

    // Randomized traffic including bad VCs, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 2) == 0;
      in_vc     = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
      in_last   = ($urandom % 3) == 0;
      in_data   = 34'($urandom);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 150) == 0;
      arst      = ($urandom % 500) == 0;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; arst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
- Single-clock, multi-virtual-channel flit buffer between the packet generator and the NoC router input.
- Used when the AXI and NoC domains share a clock, so no CDC FIFO is needed.
- Holds N_VIRT_CHN independent FIFOs and writes each flit into the FIFO selected by in_vc.
- A round-robin arbiter drains the FIFOs onto one output port, with an optional packet-lock mode that keeps all flits of a packet contiguous.

Parameters:
- FLIT_WIDTH, 34, flit payload width in bits (excludes vc id and last).
- N_VIRT_CHN, 3, number of virtual channels; must be ≥1.
- FIFO_DEPTH, 4, slots per VC; power of two, ≥2.
- LOCK_PKT, 1, 1 = hold the grant from first flit to the flit with last=1; 0 = re-arbitrate after every flit.
- VC_W, $clog2(N_VIRT_CHN) (minimum 1), width of the vc id.

Ports:
- clk_noc  in  1  clock; all logic on the rising edge.
- arst_noc  in  1  reset; active-high, synchronous (sampled only on the clk_noc rising edge).
- flush  in  1  synchronous clear of all FIFOs, arbiter state and error flag.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input flit accepted when in_valid && in_ready.
- in_vc  in  VC_W  target VC of the input flit.
- in_last  in  1  input flit is the tail of its packet.
- in_data  in  FLIT_WIDTH  input flit payload.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts the output flit.
- out_vc  out  VC_W  VC of the output flit.
- out_last  out  1  output flit is a tail.
- out_data  out  FLIT_WIDTH  output flit payload.
- occupancy  out  N_VIRT_CHN*$clog2(FIFO_DEPTH+1)  per-VC fill level; VC0 in the LSBs.
- err_bad_vc  out  1  sticky flag: an input flit was received with in_vc ≥ N_VIRT_CHN.

Behaviour:
- Reset and flush:
  - When arst_noc or flush is high at a clock edge: all pointers and occupancy counters go to 0, rr_ptr=0, FSM goes to ARB, err_bad_vc=0.
  - In the following cycle: out_valid=0, in_ready=1.
  - out_data, out_vc and out_last are 0 whenever out_valid=0.
  - Reset or flush mid-packet discards any partial packet; nothing is replayed.
- Input side:
  - in_ready = ~full[in_vc] when in_vc < N_VIRT_CHN; otherwise in_ready=1.
  - A flit with an out-of-range in_vc is dropped and sets err_bad_vc.
  - There is no write-through-when-full: a full FIFO refuses a write even if it is being read in the same cycle.
- Latency:
  - A flit written at edge t is visible as a candidate at the output in the cycle after t. There is no same-cycle bypass.
  - Minimum in→out latency is 1 cycle.
- Storage: each FIFO is a register array with a wr_ptr and rd_ptr of $clog2(FIFO_DEPTH)+1 bits. The MSB distinguishes full from empty, and pointer wrap-around is natural modulo.
- Occupancy:
  - occupancy[v] = +1 on a write to v, −1 on a read from v, unchanged on a simultaneous read and write.
  - Range is 0..FIFO_DEPTH.
- Arbiter FSM (registered grant gnt, VC_W bits):
  - ARB:
    - Pick the first non-empty VC scanning from rr_ptr upward, with wrap-around.
    - If none is non-empty, out_valid=0.
    - Otherwise out_valid=1 and the output shows that FIFO's head, same cycle (combinational from stored head).
    - On transfer (out_valid && out_ready), rr_ptr ← granted+1 mod N_VIRT_CHN.
    - Transfer with LOCK_PKT=1 and out_last=0: go to PKT with gnt=granted.
    - No transfer while out_valid=1: go to HOLD with gnt=granted.
  - HOLD:
    - Output is fixed to FIFO gnt; out_valid, out_vc, out_data and out_last must stay stable until out_ready.
    - On transfer: go to PKT if LOCK_PKT && !out_last, else ARB.
  - PKT (LOCK_PKT=1 only):
    - Only FIFO gnt is served; out_valid = ~empty[gnt].
    - Other VCs are not served even if FIFO gnt is empty (bubbles are allowed).
    - On transfer with out_last=1: go to ARB and set rr_ptr ← gnt+1.
    - A stall with out_valid=1 needs no extra state: gnt is already fixed, so the output stays stable.
- Simultaneous events: a read and a write to the same VC in one cycle are both performed. A write to a non-full FIFO is accepted while it is also being drained.
- N_VIRT_CHN=1: the arbiter degenerates to pass-through, and rr_ptr stays 0.

Decomposition:
- Add to ravenoc_pkg:
  - Typedef s_vc_flit_t {data, last, vc}.
  - Function for the occupancy width.
  - Enum arb_st_t {ARB, HOLD, PKT}.
- One natural sub-module, vc_sync_fifo (single-clock FIFO with occupancy output). It is instantiated N_VIRT_CHN times by a generate loop; the top holds only the arbiter, FSM and muxes.

Test Plan:
- Reset and fill:
  - Stimulus: assert arst_noc for 2 cycles, then write 4 flits to VC1 (0xA..0xD, last on 0xD) with out_ready=0.
  - Required: occupancy[VC1]=4, in_ready=0 for in_vc=1, in_ready=1 for in_vc=0, out_valid=1 with out_data=0xA held stable.
- Round-robin (LOCK_PKT=0):
  - Stimulus: load 2 single-flit packets into each of VC0, VC1 and VC2, then hold out_ready=1.
  - Required output vc order: 0,1,2,0,1,2.
- Packet lock (LOCK_PKT=1):
  - Stimulus: a 3-flit packet on VC2 (middle flit arrives 3 cycles late) and a 1-flit packet on VC0.
  - Required:
    - Output is VC2 flit0, bubbles, then VC2 flit1 and VC2 flit2.
    - VC0 is emitted only after VC2 flit2 (last=1).
- Full boundary:
  - Stimulus: VC0 full (4 flits) with a simultaneous out transfer and in_valid on vc0.
  - Required: in_ready=0 and the write is refused; occupancy goes 4→3; the next cycle in_ready=1.
- Bad VC:
  - Stimulus: with N_VIRT_CHN=3, send in_vc=3.
  - Required: in_ready=1, no occupancy change, err_bad_vc=1 until flush or reset.
- Flush mid-packet:
  - Stimulus: while in PKT on VC1, pulse flush for 1 cycle.
  - Required: next cycle all occupancy=0, out_valid=0, err_bad_vc=0; the next packet is arbitrated from VC0.
